exc_sched: RTL and testbench
============================

# exc_sched

Exception scheduler sitting between the MEM stage and the CP0 register file. Each cycle it collects exception flags, pending interrupts and `eret` from the committing instruction and picks one event by fixed priority. It holds the resulting `excepttype` stable until CP0 can accept it (no I-cache stall), then drives a pipeline flush and redirect PC. It also generates the sticky CP0 timer interrupt that feeds CP0 `int_i[5]`.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush_o` stays asserted per event (1..15).
- `EXC_VECTOR`, default 32'hBFC00380: redirect PC for all exceptions and interrupts.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `i_cache_stall` in 1: CP0 update inhibit. CP0 commits only when this is low.
- `mem_valid_i` in 1: the MEM-stage instruction is real (not a bubble).
- `mem_pc_i` in 32: MEM-stage instruction address.
- `mem_in_delayslot_i` in 1: MEM-stage instruction is in a delay slot.
- `mem_daddr_i` in 32: load/store effective address.
- `exc_flags_i` in 8: {eret, ades, adel_ld, ov, brk, sys, ri, adel_if}, bit 7..0.
- `status_i`, `cause_i`, `epc_i` in 32 each: current CP0 Status, Cause and EPC.
- `count_i`, `compare_i` in 32 each: current CP0 Count and Compare.
- `cp0_we_i` in 1, `cp0_waddr_i` in 5: CP0 write port, used to detect Compare writes.
- `excepttype_o` out 32: event code to CP0.
- `epc_src_o` out 32: instruction address to CP0.
- `in_delayslot_o` out 1: delay-slot flag to CP0.
- `bad_addr_o` out 32: faulting address to CP0.
- `flush_o` out 1: flush all pipeline stages.
- `newpc_o` out 32: redirect target, valid while `flush_o` is high.
- `stall_o` out 1: freezes IF..MEM.
- `timer_int_o` out 1: timer interrupt request.

## Operation
- Interrupt pending: `status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8])`.
- Detect is valid only when `mem_valid_i=1`. Priority, highest first:
  - interrupt (0x01)
  - adel_if (0x04, bad = pc)
  - ri (0x0a)
  - sys (0x08)
  - brk (0x09)
  - ov (0x0c)
  - adel_ld (0x04, bad = daddr)
  - ades (0x05, bad = daddr)
  - eret (0x0e)
- FSM states IDLE, ISSUE, FLUSH.
  - IDLE: on detect, latch code, pc, delay-slot flag, bad address and target, then go to ISSUE. Target is `epc_i` for eret, `EXC_VECTOR` otherwise.
  - ISSUE: drive the latched values on the CP0 outputs. Stay while `i_cache_stall=1`. On the first cycle with `i_cache_stall=0`, go to FLUSH and load the flush counter with `FLUSH_CYCLES`.
  - FLUSH: `flush_o=1` and `newpc_o`=target. Count down; at 1, return to IDLE. `i_cache_stall` is ignored here.
- `excepttype_o`=0 in every state except ISSUE, so CP0 commits exactly once.
- `stall_o = (state != IDLE) | detect_in_IDLE`.
- Events arriving while not in IDLE are ignored; the pipeline is frozen, so the instruction is re-presented afterwards.
- Multiple flags in one cycle: only the highest-priority one is taken.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state IDLE, counter 0
  - `excepttype_o`, `epc_src_o`, `bad_addr_o`, `newpc_o` = 0
  - `in_delayslot_o`, `flush_o`, `timer_int_o` = 0
- Reset asserted mid-ISSUE or mid-FLUSH aborts immediately; nothing is committed.
- Best-case latency: detect in cycle N, `excepttype_o` valid in N+1 (CP0 commits at the end of N+1), `flush_o` high in N+2..N+1+FLUSH_CYCLES, IDLE again in N+2+FLUSH_CYCLES.
- Each stalled cycle in ISSUE adds exactly one cycle.
- All outputs are registered except `stall_o`.

## Configuration
- `CP0_TIMER_INT_EN` defined:
  - `timer_int_o` is set on the cycle after `count_i == compare_i` with `compare_i != 0`.
  - Set is sticky.
  - Cleared on the cycle after `cp0_we_i=1` with `cp0_waddr_i=11`.
  - If set and clear occur in the same cycle, clear wins.
- Undefined: `timer_int_o` is tied to 0 and the comparator logic is absent.

## Test plan
- Syscall: pc=0x80001000, not in delay slot, `i_cache_stall=0` -> `excepttype_o`=0x08 for exactly 1 cycle, then `flush_o` for 2 cycles with `newpc_o`=0xBFC00380.
- ri+ov together, delay slot=1, pc=0x80000104 -> code 0x0a, `in_delayslot_o`=1, `epc_src_o`=0x80000104.
- Store misaligned, daddr=0x80002003, `i_cache_stall` high for 3 cycles in ISSUE -> code 0x05 held 4 cycles, `bad_addr_o`=0x80002003, `flush_o` only afterwards.
- eret with `epc_i`=0x80000200 -> code 0x0e, `newpc_o`=0x80000200.
- Interrupt: status=0x0000_0401, cause[10]=1, with sys also set -> code 0x01. Same case with status[1]=1 -> code 0x08.
- With `CP0_TIMER_INT_EN`: count=compare=0x100 -> `timer_int_o`=1 next cycle and remains 1; write Compare -> 0 next cycle. rst=0 mid-FLUSH -> all outputs 0 immediately.

Source files
------------

// File: rtl/exc_sched.sv
// Fixed-priority exception scheduler: detect -> CP0 code held while i_cache_stall (1+ cycles) -> FLUSH_CYCLES of flush.
// stall_o freezes the pipeline from detect until idle; CP0_TIMER_INT_EN adds the sticky Count/Compare timer interrupt.
module exc_sched #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cache_stall,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_daddr_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] count_i,
    input  logic [31:0] compare_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] epc_src_o,
    output logic        in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        stall_o,
    output logic        timer_int_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] exc_q, exc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_q, bad_d;
    logic [31:0] tgt_q, tgt_d;
    logic        ds_q, ds_d;
    logic        flush_q, flush_d;

    logic        int_pend;
    logic        detect;
    logic [31:0] code_sel;
    logic [31:0] bad_sel;

    assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    assign detect   = mem_valid_i & (int_pend | (|exc_flags_i));

    // Flag bits 0..6 are already in priority order, so the lowest set bit wins after interrupts.
    always_comb begin
        code_sel = 32'h0;
        bad_sel  = 32'h0;
        if (int_pend)            code_sel = 32'h01;
        else if (exc_flags_i[0]) begin code_sel = 32'h04; bad_sel = mem_pc_i; end
        else if (exc_flags_i[1]) code_sel = 32'h0a;
        else if (exc_flags_i[2]) code_sel = 32'h08;
        else if (exc_flags_i[3]) code_sel = 32'h09;
        else if (exc_flags_i[4]) code_sel = 32'h0c;
        else if (exc_flags_i[5]) begin code_sel = 32'h04; bad_sel = mem_daddr_i; end
        else if (exc_flags_i[6]) begin code_sel = 32'h05; bad_sel = mem_daddr_i; end
        else if (exc_flags_i[7]) code_sel = 32'h0e;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exc_d   = exc_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        tgt_d   = tgt_q;
        ds_d    = ds_q;
        flush_d = flush_q;
        case (state_q)
            S_IDLE: begin
                if (detect) begin
                    state_d = S_ISSUE;
                    exc_d   = code_sel;
                    pc_d    = mem_pc_i;
                    ds_d    = mem_in_delayslot_i;
                    bad_d   = bad_sel;
                    tgt_d   = (code_sel == 32'h0e) ? epc_i : EXC_VECTOR;
                end
            end
            S_ISSUE: begin
                if (!i_cache_stall) begin
                    state_d = S_FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES);
                    exc_d   = 32'h0;
                    flush_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                exc_d   = 32'h0;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            exc_q   <= 32'h0;
            pc_q    <= 32'h0;
            bad_q   <= 32'h0;
            tgt_q   <= 32'h0;
            ds_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            tgt_q   <= tgt_d;
            ds_q    <= ds_d;
            flush_q <= flush_d;
        end
    end

    assign excepttype_o   = exc_q;
    assign epc_src_o      = pc_q;
    assign in_delayslot_o = ds_q;
    assign bad_addr_o     = bad_q;
    assign flush_o        = flush_q;
    assign newpc_o        = tgt_q;
    assign stall_o        = (state_q != S_IDLE) | detect;

`ifdef CP0_TIMER_INT_EN
    logic timer_q, timer_d;
    logic timer_clr;
    logic unused_sig;

    assign timer_clr = cp0_we_i & (cp0_waddr_i == 5'd11);
    // Clear has priority so a Compare write in the match cycle leaves the request low.
    assign timer_d   = timer_clr ? 1'b0
                     : (((count_i == compare_i) && (compare_i != 32'h0)) ? 1'b1 : timer_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_q <= 1'b0;
        else      timer_q <= timer_d;
    end

    assign timer_int_o = timer_q;
    assign unused_sig  = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
`else
    logic unused_sig;

    assign timer_int_o = 1'b0;
    assign unused_sig  = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0],
                           count_i, compare_i, cp0_we_i, cp0_waddr_i};
`endif
endmodule

// File: tb/tb_exc_sched.sv
// Self-checking bench for exc_sched: directed test-plan cases plus randomized events against a priority-table model.
module tb_exc_sched;
    localparam int          FC   = 2;
    localparam logic [31:0] EXCV = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_cache_stall = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_pc_i = '0;
    logic        mem_in_delayslot_i = 1'b0;
    logic [31:0] mem_daddr_i = '0;
    logic [7:0]  exc_flags_i = '0;
    logic [31:0] status_i = '0, cause_i = '0, epc_i = 32'h80000200;
    logic [31:0] count_i = '0, compare_i = '0;
    logic        cp0_we_i = 1'b0;
    logic [4:0]  cp0_waddr_i = '0;
    logic [31:0] excepttype_o, epc_src_o, bad_addr_o, newpc_o;
    logic        in_delayslot_o, flush_o, stall_o, timer_int_o;

    int errors = 0;
    int checks = 0;

    exc_sched #(.FLUSH_CYCLES(FC), .EXC_VECTOR(EXCV)) dut (
        .clk(clk), .rst(rst), .i_cache_stall(i_cache_stall),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
        .mem_daddr_i(mem_daddr_i), .exc_flags_i(exc_flags_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .count_i(count_i), .compare_i(compare_i), .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i),
        .excepttype_o(excepttype_o), .epc_src_o(epc_src_o), .in_delayslot_o(in_delayslot_o),
        .bad_addr_o(bad_addr_o), .flush_o(flush_o), .newpc_o(newpc_o),
        .stall_o(stall_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: interrupt first, then the flag list walked in priority order (bit 0 upward).
    function automatic void model(input logic v, input logic [7:0] f, input logic [31:0] st, ca, pc, da, ep,
                                  output logic hit, output logic [31:0] code, bad, tgt);
        logic [7:0] ctab [8];
        ctab = '{8'h04, 8'h0a, 8'h08, 8'h09, 8'h0c, 8'h04, 8'h05, 8'h0e};
        hit = 1'b0; code = 32'h0; bad = 32'h0; tgt = EXCV;
        if (!v) return;
        if (st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h0)) begin
            hit = 1'b1; code = 32'h01; return;
        end
        for (int i = 0; i < 8; i++) begin
            if (f[i]) begin
                hit = 1'b1; code = {24'h0, ctab[i]};
                if (i == 0) bad = pc;
                if (i == 5 || i == 6) bad = da;
                if (i == 7) tgt = ep;
                return;
            end
        end
    endfunction

    task automatic run_event(input string nm, input logic v, input logic [7:0] f, input logic [31:0] st, ca,
                             input logic [31:0] pc, da, input logic ds, input int nstall);
        logic hit;
        logic [31:0] ec, eb, et;
        model(v, f, st, ca, pc, da, epc_i, hit, ec, eb, et);
        tick();
        mem_valid_i = v; exc_flags_i = f; status_i = st; cause_i = ca;
        mem_pc_i = pc; mem_daddr_i = da; mem_in_delayslot_i = ds; i_cache_stall = 1'b0;
        @(negedge clk);
        checks++; if (stall_o !== hit) begin errors++; $display("FAIL %s detect_stall got=%b exp=%b", nm, stall_o, hit); end
        checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL %s code_early got=%h exp=0", nm, excepttype_o); end
        tick();
        mem_valid_i = 1'b0; exc_flags_i = 8'h0;
        if (!hit) begin
            @(negedge clk);
            checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin errors++;
                $display("FAIL %s no_event got code=%h flush=%b exp 0/0", nm, excepttype_o, flush_o); end
            return;
        end
        for (int k = 0; k <= nstall; k++) begin
            if (k > 0) tick();
            i_cache_stall = (k < nstall);
            @(negedge clk);
            checks++; if (excepttype_o !== ec) begin errors++; $display("FAIL %s code[%0d] got=%h exp=%h", nm, k, excepttype_o, ec); end
            checks++; if (epc_src_o !== pc || in_delayslot_o !== ds || bad_addr_o !== eb) begin errors++;
                $display("FAIL %s cp0_vals got pc=%h ds=%b bad=%h exp pc=%h ds=%b bad=%h", nm, epc_src_o, in_delayslot_o, bad_addr_o, pc, ds, eb); end
            checks++; if (flush_o !== 1'b0 || stall_o !== 1'b1) begin errors++;
                $display("FAIL %s issue_ctl got flush=%b stall=%b exp 0/1", nm, flush_o, stall_o); end
        end
        for (int k = 0; k < FC; k++) begin
            tick();
            i_cache_stall = 1'($urandom);
            @(negedge clk);
            checks++; if (flush_o !== 1'b1 || newpc_o !== et || excepttype_o !== 32'h0 || stall_o !== 1'b1) begin errors++;
                $display("FAIL %s flush[%0d] got f=%b pc=%h code=%h st=%b exp 1/%h/0/1", nm, k, flush_o, newpc_o, excepttype_o, stall_o, et); end
        end
        tick();
        i_cache_stall = 1'b0;
        @(negedge clk);
        checks++; if (flush_o !== 1'b0 || stall_o !== 1'b0 || excepttype_o !== 32'h0) begin errors++;
            $display("FAIL %s back_idle got f=%b st=%b code=%h exp 0/0/0", nm, flush_o, stall_o, excepttype_o); end
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({excepttype_o, epc_src_o, bad_addr_o, newpc_o, in_delayslot_o, flush_o, timer_int_o, stall_o} !== '0) begin errors++;
            $display("FAIL reset_vals got code=%h pc=%h bad=%h npc=%h ds=%b f=%b t=%b st=%b exp all 0",
                     excepttype_o, epc_src_o, bad_addr_o, newpc_o, in_delayslot_o, flush_o, timer_int_o, stall_o); end
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_directed();
        run_event("syscall", 1'b1, 8'h04, 32'h0, 32'h0, 32'h80001000, 32'h0, 1'b0, 0);
        run_event("ri_ov_ds", 1'b1, 8'h12, 32'h0, 32'h0, 32'h80000104, 32'h0, 1'b1, 0);
        run_event("ades_stall", 1'b1, 8'h40, 32'h0, 32'h0, 32'h80000300, 32'h80002003, 1'b0, 3);
        run_event("eret", 1'b1, 8'h80, 32'h0, 32'h0, 32'h80000310, 32'h0, 1'b0, 0);
        run_event("int_sys", 1'b1, 8'h04, 32'h401, 32'h400, 32'h80000400, 32'h0, 1'b0, 0);
        run_event("exl_sys", 1'b1, 8'h04, 32'h403, 32'h400, 32'h80000404, 32'h0, 1'b0, 1);
        run_event("adel_if", 1'b1, 8'hE1, 32'h0, 32'h0, 32'h80000501, 32'h80009999, 1'b0, 0);
        run_event("adel_ld", 1'b1, 8'hA0, 32'h0, 32'h0, 32'h80000600, 32'h80004002, 1'b1, 2);
        run_event("bubble", 1'b0, 8'h04, 32'h401, 32'h400, 32'h80000700, 32'h0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_event("rand", ($urandom % 4) != 0, 8'($urandom) & 8'($urandom),
                      {16'h0, 8'($urandom), 6'h0, 2'($urandom)}, {16'h0, 8'($urandom) & 8'($urandom), 8'h0},
                      $urandom, $urandom, 1'($urandom), $urandom % 4);
        end
    endtask

    task automatic test_busy_ignore();
        tick();
        mem_valid_i = 1'b1; exc_flags_i = 8'h04; status_i = 32'h0; cause_i = 32'h0; mem_pc_i = 32'h80000800;
        tick();
        exc_flags_i = 8'h02;
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h08) begin errors++; $display("FAIL busy_issue got=%h exp=08", excepttype_o); end
        for (int k = 0; k < FC; k++) tick();
        @(negedge clk);
        checks++; if (flush_o !== 1'b1 || excepttype_o !== 32'h0) begin errors++;
            $display("FAIL busy_flush got f=%b code=%h exp 1/0", flush_o, excepttype_o); end
        tick();
        @(negedge clk);
        checks++; if (stall_o !== 1'b1 || flush_o !== 1'b0) begin errors++;
            $display("FAIL busy_represent got st=%b f=%b exp 1/0", stall_o, flush_o); end
        tick();
        mem_valid_i = 1'b0; exc_flags_i = 8'h0;
        @(negedge clk);
        checks++; if (excepttype_o !== 32'h0a) begin errors++; $display("FAIL busy_second got=%h exp=0a", excepttype_o); end
        for (int k = 0; k < FC + 1; k++) tick();
        @(negedge clk);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL busy_drain got=%b exp=0", stall_o); end
    endtask

    task automatic test_reset_midflush();
        tick();
        mem_valid_i = 1'b1; exc_flags_i = 8'h08; mem_pc_i = 32'h80000900; mem_in_delayslot_i = 1'b1;
        tick();
        mem_valid_i = 1'b0; exc_flags_i = 8'h0;
        tick();
        @(negedge clk);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rst_pre flush got=%b exp=1", flush_o); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({excepttype_o, epc_src_o, bad_addr_o, newpc_o, in_delayslot_o, flush_o, timer_int_o, stall_o} !== '0) begin errors++;
            $display("FAIL rst_midflush got code=%h pc=%h npc=%h ds=%b f=%b st=%b exp all 0",
                     excepttype_o, epc_src_o, newpc_o, in_delayslot_o, flush_o, stall_o); end
        tick();
        rst = 1'b1; mem_in_delayslot_i = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (flush_o !== 1'b0 || stall_o !== 1'b0) begin errors++;
            $display("FAIL rst_after got f=%b st=%b exp 0/0", flush_o, stall_o); end
    endtask

    task automatic test_timer();
`ifdef CP0_TIMER_INT_EN
        tick(); count_i = 32'h100; compare_i = 32'h100;
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL timer_early got=%b exp=0", timer_int_o); end
        tick(); count_i = 32'h101;
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL timer_set got=%b exp=1", timer_int_o); end
        tick(); cp0_we_i = 1'b1; cp0_waddr_i = 5'd12;
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL timer_sticky got=%b exp=1", timer_int_o); end
        tick(); cp0_waddr_i = 5'd11;
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL timer_wr_cycle got=%b exp=1", timer_int_o); end
        tick(); cp0_we_i = 1'b0;
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL timer_clear got=%b exp=0", timer_int_o); end
        tick(); count_i = 32'h200; compare_i = 32'h200; cp0_we_i = 1'b1;
        tick(); cp0_we_i = 1'b0; count_i = 32'h0; compare_i = 32'h0;
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL timer_clr_wins got=%b exp=0", timer_int_o); end
        tick();
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL timer_zero_cmp got=%b exp=0", timer_int_o); end
`else
        tick(); count_i = 32'h100; compare_i = 32'h100;
        tick();
        @(negedge clk);
        checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL timer_tied got=%b exp=0", timer_int_o); end
`endif
        count_i = 32'h0; compare_i = 32'h0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_random();
        test_timer();
        test_reset_midflush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
